// File: rtl/answer_generator.sv
// Secret-answer generator for the number-guessing game: LFSR-driven rejection
// sampling into a shadow register, published atomically with a write_enable pulse.

// One digit field: holds the shadow digit being built and the published digit.
module answer_digit_slot #(
  parameter int DIGIT_W = 4,
  parameter int K       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               publish,
  input  logic [K-1:0]       cand,
  output logic [DIGIT_W-1:0] answer_digit
);

  logic [DIGIT_W-1:0] shadow;
  logic [DIGIT_W-1:0] cand_digit;

  assign cand_digit = DIGIT_W'(cand) + DIGIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      answer_digit <= '0;
    end else begin
      if (clear)
        shadow <= '0;
      else if (load)
        shadow <= cand_digit;
      // The final digit lands in the same edge it is accepted, so bypass it.
      if (publish)
        answer_digit <= load ? cand_digit : shadow;
    end
  end

endmodule

module answer_generator #(
  parameter int          DIGITS    = 8,
  parameter int          DIGIT_W   = 4,
  parameter int          MAX_DIGIT = 8,
  parameter int          UNIQUE    = 0,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      change_answer,
  output logic [DIGITS*DIGIT_W-1:0] answer,
  output logic                      write_enable,
  output logic                      busy
);

  localparam int          K         = $clog2(MAX_DIGIT);
  localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [K:0]  MAX_C     = (K+1)'(MAX_DIGIT);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        lfsr;
  logic               req_prev;
  logic               req;
  logic [K-1:0]       cand;
  logic [2**K-1:0]    used;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               last;
  logic               clear;
  logic               publish;

  assign req  = change_answer & ~req_prev;
  assign cand = lfsr[K-1:0];
  assign last = (idx == IDX_W'(DIGITS - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear     = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          clear     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        accept = ({1'b0, cand} < MAX_C) && ((UNIQUE == 0) || !used[cand]);
        if (accept && last) begin
          publish   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // req_prev keeps sampling through reset so a level held across reset is not an edge.
  always_ff @(posedge clk) begin
    req_prev <= change_answer;
    if (rst) begin
      lfsr         <= LFSR_INIT;
      used         <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      write_enable <= 1'b0;
    end else begin
      lfsr         <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
      busy         <= (state_nxt != IDLE);
      write_enable <= publish;
      if (clear) begin
        used <= '0;
        idx  <= '0;
      end else if (accept) begin
        used[cand] <= 1'b1;
        if (!last) idx <= idx + IDX_W'(1);
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_slot
    answer_digit_slot #(
      .DIGIT_W (DIGIT_W),
      .K       (K)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .load         (accept && (idx == IDX_W'(g))),
      .publish      (publish),
      .cand         (cand),
      .answer_digit (answer[g*DIGIT_W +: DIGIT_W])
    );
  end

endmodule
